conv_transpose2d: RTL and testbench

Sequential transposed-convolution (deconvolution) engine: upsamples a flat NCHW tensor with a learned kernel and is the decoder-side counterpart of the strided `conv2d` downsampler. It uses the same flat tensor packing, so an encoder `conv2d` output can feed it directly. It computes one output element at a time in gather form with a single signed MAC, under a start/busy/done handshake. It replaces a fully unrolled datapath with a small, deterministic-latency one.

---
 rtl/conv_transpose2d.sv | 213 +++++++++++++++++++++
 tb/tb_conv_transpose2d.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_transpose2d.sv
`default_nettype none
// ============================================================================
// Module      : conv_transpose2d
// Description : Sequential gather-form transposed convolution on flat NCHW
//               tensors, one output element at a time through a single MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_transpose2d #(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_HEIGHT    = 2,
    parameter int IN_WIDTH     = 2,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]         input_tensor_flat,
    input  logic [IN_CHANNELS*OUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]  weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                      bias_flat,
    output logic busy,
    output logic done,
    output logic [BATCH_SIZE*OUT_CHANNELS*((IN_HEIGHT-1)*STRIDE-2*PADDING+KERNEL_SIZE)*((IN_WIDTH-1)*STRIDE-2*PADDING+KERNEL_SIZE)*DATA_WIDTH-1:0] output_tensor_flat
);
    localparam int C_OUT_HEIGHT = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int C_OUT_WIDTH  = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int C_OUT_ELEMS  = BATCH_SIZE * OUT_CHANNELS * C_OUT_HEIGHT * C_OUT_WIDTH;
    localparam int C_IN_ELEMS   = BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int C_W_ELEMS    = IN_CHANNELS * OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;

    localparam int C_B_W  = (BATCH_SIZE   > 1) ? $clog2(BATCH_SIZE)   : 1;
    localparam int C_IC_W = (IN_CHANNELS  > 1) ? $clog2(IN_CHANNELS)  : 1;
    localparam int C_OC_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int C_K_W  = (KERNEL_SIZE  > 1) ? $clog2(KERNEL_SIZE)  : 1;
    localparam int C_OH_W = (C_OUT_HEIGHT > 1) ? $clog2(C_OUT_HEIGHT) : 1;
    localparam int C_OW_W = (C_OUT_WIDTH  > 1) ? $clog2(C_OUT_WIDTH)  : 1;
    localparam int C_E_W  = (C_OUT_ELEMS  > 1) ? $clog2(C_OUT_ELEMS)  : 1;
    localparam int C_XI_W = (C_IN_ELEMS   > 1) ? $clog2(C_IN_ELEMS)   : 1;
    localparam int C_WI_W = (C_W_ELEMS    > 1) ? $clog2(C_W_ELEMS)    : 1;

    localparam logic [C_B_W-1:0]  C_B_LAST  = C_B_W'(BATCH_SIZE - 1);
    localparam logic [C_IC_W-1:0] C_IC_LAST = C_IC_W'(IN_CHANNELS - 1);
    localparam logic [C_OC_W-1:0] C_OC_LAST = C_OC_W'(OUT_CHANNELS - 1);
    localparam logic [C_K_W-1:0]  C_K_LAST  = C_K_W'(KERNEL_SIZE - 1);
    localparam logic [C_OH_W-1:0] C_OH_LAST = C_OH_W'(C_OUT_HEIGHT - 1);
    localparam logic [C_OW_W-1:0] C_OW_LAST = C_OW_W'(C_OUT_WIDTH - 1);
    localparam logic [C_E_W-1:0]  C_E_LAST  = C_E_W'(C_OUT_ELEMS - 1);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_INIT  = 3'd1;
    localparam logic [2:0] C_ST_MAC   = 3'd2;
    localparam logic [2:0] C_ST_WRITE = 3'd3;
    localparam logic [2:0] C_ST_DONE  = 3'd4;

    logic [2:0]            r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [C_B_W-1:0]      r_b;
    logic [C_OC_W-1:0]     r_oc;
    logic [C_OH_W-1:0]     r_oh;
    logic [C_OW_W-1:0]     r_ow;
    logic [C_IC_W-1:0]     r_ic;
    logic [C_K_W-1:0]      r_kh, r_kw;
    logic [C_E_W-1:0]      r_elem;

    logic [DATA_WIDTH-1:0] w_x_in [C_IN_ELEMS];
    logic [DATA_WIDTH-1:0] w_w_in [C_W_ELEMS];
    logic [DATA_WIDTH-1:0] w_b_in [OUT_CHANNELS];
    logic [DATA_WIDTH-1:0] r_x    [C_IN_ELEMS];
    logic [DATA_WIDTH-1:0] r_w    [C_W_ELEMS];
    logic [DATA_WIDTH-1:0] r_bias [OUT_CHANNELS];
    logic [DATA_WIDTH-1:0] r_out  [C_OUT_ELEMS];

    genvar g;
    generate
        for (g = 0; g < C_IN_ELEMS; g++) begin : g_x_in
            assign w_x_in[g] = input_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH];
        end
        for (g = 0; g < C_W_ELEMS; g++) begin : g_w_in
            assign w_w_in[g] = weights_flat[g*DATA_WIDTH +: DATA_WIDTH];
        end
        for (g = 0; g < OUT_CHANNELS; g++) begin : g_b_in
            assign w_b_in[g] = bias_flat[g*DATA_WIDTH +: DATA_WIDTH];
        end
        for (g = 0; g < C_OUT_ELEMS; g++) begin : g_out
            assign output_tensor_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_out[g];
        end
    endgenerate

    logic signed [31:0]    w_th, w_tw;
    logic                  w_valid;
    logic [C_XI_W-1:0]     w_xi;
    logic [C_WI_W-1:0]     w_wi;
    logic [DATA_WIDTH-1:0] w_prod;
    logic                  w_last_tap, w_last_elem;

    // Gather form: output (oh,ow) pulls from the input pixel whose stride grid lands on it.
    always_comb begin
        w_th    = 32'(r_oh) + 32'(PADDING) - 32'(r_kh);
        w_tw    = 32'(r_ow) + 32'(PADDING) - 32'(r_kw);
        w_valid = !w_th[31] && !w_tw[31] &&
                  (w_th % STRIDE == 0) && (w_tw % STRIDE == 0) &&
                  (w_th / STRIDE < IN_HEIGHT) && (w_tw / STRIDE < IN_WIDTH);
        w_xi    = '0;
        if (w_valid)
            w_xi = C_XI_W'(((32'(r_b) * IN_CHANNELS + 32'(r_ic)) * IN_HEIGHT + 32'(w_th / STRIDE))
                           * IN_WIDTH + 32'(w_tw / STRIDE));
        w_wi    = C_WI_W'((32'(r_ic) * OUT_CHANNELS + 32'(r_oc)) * KERNEL_SIZE * KERNEL_SIZE
                          + 32'(r_kh) * KERNEL_SIZE + 32'(r_kw));
        w_prod  = r_x[w_xi] * r_w[w_wi];
        w_last_tap  = (r_ic == C_IC_LAST) && (r_kh == C_K_LAST) && (r_kw == C_K_LAST);
        w_last_elem = (r_elem == C_E_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= C_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE:  if (start) w_state_nxt = C_ST_INIT;
            C_ST_INIT:  w_state_nxt = C_ST_MAC;
            C_ST_MAC:   if (w_last_tap) w_state_nxt = C_ST_WRITE;
            C_ST_WRITE: w_state_nxt = w_last_elem ? C_ST_DONE : C_ST_INIT;
            C_ST_DONE:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == C_ST_INIT) || (r_state == C_ST_MAC) || (r_state == C_ST_WRITE);
        done = (r_state == C_ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_oc   <= '0;
            r_oh   <= '0;
            r_ow   <= '0;
            r_ic   <= '0;
            r_kh   <= '0;
            r_kw   <= '0;
            r_elem <= '0;
            r_x    <= '{default: '0};
            r_w    <= '{default: '0};
            r_bias <= '{default: '0};
            r_out  <= '{default: '0};
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (start) begin
                        r_x    <= w_x_in;
                        r_w    <= w_w_in;
                        r_bias <= w_b_in;
                        r_b    <= '0;
                        r_oc   <= '0;
                        r_oh   <= '0;
                        r_ow   <= '0;
                        r_ic   <= '0;
                        r_kh   <= '0;
                        r_kw   <= '0;
                        r_elem <= '0;
                    end
                end
                C_ST_INIT: r_acc <= r_bias[r_oc];
                C_ST_MAC: begin
                    if (w_valid) r_acc <= r_acc + w_prod;
                    // Tap counters wrap to zero after the last tap, ready for the next element.
                    if (r_kw == C_K_LAST) begin
                        r_kw <= '0;
                        if (r_kh == C_K_LAST) begin
                            r_kh <= '0;
                            r_ic <= (r_ic == C_IC_LAST) ? '0 : r_ic + 1'b1;
                        end else begin
                            r_kh <= r_kh + 1'b1;
                        end
                    end else begin
                        r_kw <= r_kw + 1'b1;
                    end
                end
                C_ST_WRITE: begin
                    r_out[r_elem] <= r_acc;
                    r_elem <= w_last_elem ? '0 : r_elem + 1'b1;
                    if (r_ow == C_OW_LAST) begin
                        r_ow <= '0;
                        if (r_oh == C_OH_LAST) begin
                            r_oh <= '0;
                            if (r_oc == C_OC_LAST) begin
                                r_oc <= '0;
                                r_b  <= (r_b == C_B_LAST) ? '0 : r_b + 1'b1;
                            end else begin
                                r_oc <= r_oc + 1'b1;
                            end
                        end else begin
                            r_oh <= r_oh + 1'b1;
                        end
                    end else begin
                        r_ow <= r_ow + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_conv_transpose2d.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_transpose2d
// Description : Self-checking bench; scatter-form reference model, two configs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_transpose2d;
    localparam int DW  = 32;
    localparam int IN0 = 4,  WN0 = 8,  BN0 = 2, ON0 = 32;
    localparam int IN1 = 16, WN1 = 18, BN1 = 1, ON1 = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1;
    logic busy0, done0, busy1, done1;
    logic [IN0*DW-1:0] x0;
    logic [WN0*DW-1:0] w0;
    logic [BN0*DW-1:0] b0;
    logic [ON0*DW-1:0] y0;
    logic [IN1*DW-1:0] x1;
    logic [WN1*DW-1:0] w1;
    logic [BN1*DW-1:0] b1;
    logic [ON1*DW-1:0] y1;

    conv_transpose2d dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .input_tensor_flat(x0), .weights_flat(w0), .bias_flat(b0),
        .busy(busy0), .done(done0), .output_tensor_flat(y0)
    );

    conv_transpose2d #(
        .BATCH_SIZE(2), .IN_CHANNELS(2), .OUT_CHANNELS(1), .IN_HEIGHT(2), .IN_WIDTH(2),
        .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1), .DATA_WIDTH(32)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .input_tensor_flat(x1), .weights_flat(w1), .bias_flat(b1),
        .busy(busy1), .done(done1), .output_tensor_flat(y1)
    );

    int cfg_b[2]  = '{1, 2};
    int cfg_ic[2] = '{1, 2};
    int cfg_oc[2] = '{2, 1};
    int cfg_ih[2] = '{2, 2};
    int cfg_iw[2] = '{2, 2};
    int cfg_k[2]  = '{2, 3};
    int cfg_s[2]  = '{2, 2};
    int cfg_p[2]  = '{0, 1};

    int xa[], wa[], ba[], eo[];
    int n_checks = 0, n_pass = 0;

    bit   mon_on = 1'b0, mon_fin = 1'b0;
    int   mon_which, mon_cyc, mon_n, mon_t, mon_done_cyc, mon_e;
    logic mon_b, mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    function automatic logic [31:0] dut_out(input int wh, input int e);
        if (wh == 0) return y0[e*DW +: DW];
        return y1[e*DW +: DW];
    endfunction

    task automatic alloc(input int wh, input bit rnd);
        xa = new[cfg_b[wh]*cfg_ic[wh]*cfg_ih[wh]*cfg_iw[wh]];
        wa = new[cfg_ic[wh]*cfg_oc[wh]*cfg_k[wh]*cfg_k[wh]];
        ba = new[cfg_oc[wh]];
        foreach (xa[i]) xa[i] = rnd ? (($urandom_range(1) == 1) ? int'($urandom) : int'($urandom_range(20)) - 10) : 0;
        foreach (wa[i]) wa[i] = rnd ? (($urandom_range(1) == 1) ? int'($urandom) : int'($urandom_range(20)) - 10) : 0;
        foreach (ba[i]) ba[i] = rnd ? int'($urandom) : 0;
    endtask

    // Scatter form: every input pixel spreads its weighted kernel onto the output grid.
    task automatic model(input int wh);
        int nb, nic, noc, ih_n, iw_n, k, s, p, oh_n, ow_n, oh, ow;
        nb = cfg_b[wh]; nic = cfg_ic[wh]; noc = cfg_oc[wh];
        ih_n = cfg_ih[wh]; iw_n = cfg_iw[wh]; k = cfg_k[wh]; s = cfg_s[wh]; p = cfg_p[wh];
        oh_n = (ih_n - 1) * s - 2 * p + k;
        ow_n = (iw_n - 1) * s - 2 * p + k;
        eo = new[nb*noc*oh_n*ow_n];
        for (int b = 0; b < nb; b++)
            for (int oc = 0; oc < noc; oc++)
                for (int i = 0; i < oh_n*ow_n; i++)
                    eo[(b*noc+oc)*oh_n*ow_n + i] = ba[oc];
        for (int b = 0; b < nb; b++)
            for (int ic = 0; ic < nic; ic++)
                for (int ih = 0; ih < ih_n; ih++)
                    for (int iw = 0; iw < iw_n; iw++)
                        for (int oc = 0; oc < noc; oc++)
                            for (int kh = 0; kh < k; kh++)
                                for (int kw = 0; kw < k; kw++) begin
                                    oh = ih*s + kh - p;
                                    ow = iw*s + kw - p;
                                    if (oh >= 0 && oh < oh_n && ow >= 0 && ow < ow_n)
                                        eo[((b*noc+oc)*oh_n+oh)*ow_n+ow] += xa[((b*nic+ic)*ih_n+ih)*iw_n+iw]
                                                                           * wa[(ic*noc+oc)*k*k + kh*k + kw];
                                end
    endtask

    task automatic pack(input int wh);
        if (wh == 0) begin
            for (int i = 0; i < IN0; i++) x0[i*DW +: DW] = xa[i];
            for (int i = 0; i < WN0; i++) w0[i*DW +: DW] = wa[i];
            for (int i = 0; i < BN0; i++) b0[i*DW +: DW] = ba[i];
        end else begin
            for (int i = 0; i < IN1; i++) x1[i*DW +: DW] = xa[i];
            for (int i = 0; i < WN1; i++) w1[i*DW +: DW] = wa[i];
            for (int i = 0; i < BN1; i++) b1[i*DW +: DW] = ba[i];
        end
    endtask

    task automatic scramble(input int wh);
        if (wh == 0) begin
            for (int i = 0; i < IN0; i++) x0[i*DW +: DW] = $urandom;
            for (int i = 0; i < WN0; i++) w0[i*DW +: DW] = $urandom;
            for (int i = 0; i < BN0; i++) b0[i*DW +: DW] = $urandom;
        end else begin
            for (int i = 0; i < IN1; i++) x1[i*DW +: DW] = $urandom;
            for (int i = 0; i < WN1; i++) w1[i*DW +: DW] = $urandom;
            for (int i = 0; i < BN1; i++) b1[i*DW +: DW] = $urandom;
        end
    endtask

    // Cycle-by-cycle compare against the timeline and model, relative to the accept edge.
    always @(negedge clk) begin
        if (mon_on) begin
            mon_cyc = mon_cyc + 1;
            mon_b = (mon_which == 0) ? busy0 : busy1;
            mon_d = (mon_which == 0) ? done0 : done1;
            check($sformatf("busy@%0d", mon_cyc), {31'b0, mon_b}, {31'b0, (mon_cyc >= 1 && mon_cyc <= mon_t)});
            check($sformatf("done@%0d", mon_cyc), {31'b0, mon_d}, {31'b0, (mon_cyc == mon_t + 1)});
            if (mon_d && mon_done_cyc < 0) mon_done_cyc = mon_cyc;
            if (mon_cyc > mon_n + 2 && (mon_cyc - 1) % (mon_n + 2) == 0) begin
                mon_e = (mon_cyc - 1) / (mon_n + 2) - 1;
                check($sformatf("elem%0d", mon_e), dut_out(mon_which, mon_e), eo[mon_e]);
            end
            if (mon_cyc == mon_t + 1)
                foreach (eo[e]) check($sformatf("final%0d", e), dut_out(mon_which, e), eo[e]);
            if (mon_cyc == mon_t + 3) begin
                mon_on  = 1'b0;
                mon_fin = 1'b1;
            end
        end
    end

    task automatic begin_run(input int wh);
        model(wh);
        pack(wh);
        @(posedge clk); #1;
        if (wh == 0) start0 = 1'b1; else start1 = 1'b1;
        mon_which    = wh;
        mon_n        = cfg_ic[wh] * cfg_k[wh] * cfg_k[wh];
        mon_t        = eo.size() * (mon_n + 2);
        mon_cyc      = -1;
        mon_done_cyc = -1;
        mon_fin      = 1'b0;
        mon_on       = 1'b1;
        @(posedge clk); #1;
        scramble(wh);
    endtask

    task automatic run(input int wh, input bit hold);
        int guard;
        begin_run(wh);
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        guard = 0;
        while (!mon_fin && guard < mon_t + 20) begin
            if (hold && mon_cyc >= mon_t + 1) begin start0 = 1'b0; start1 = 1'b0; end
            @(posedge clk); #1;
            guard++;
        end
        if (!mon_fin) begin
            n_checks++;
            $display("FAIL timeout: run on dut%0d did not complete, cycle %0d of %0d", wh, mon_cyc, mon_t + 3);
            mon_on = 1'b0;
        end
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    int lit_e[13] = '{0, 2, 5, 8, 15, 16, 17, 18, 19, 20, 21, 22, 23};
    int lit_v[13] = '{1, 2, 1, 3, 4, 11, 12, 12, 14, 13, 14, 16, 18};

    initial begin
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        x0 = '0; w0 = '0; b0 = '0; x1 = '0; w1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", {31'b0, busy0}, 0);
        check("rst_done0", {31'b0, done0}, 0);
        check("rst_busy1", {31'b0, busy1}, 0);
        check("rst_done1", {31'b0, done1}, 0);
        for (int e = 0; e < ON0; e++) check($sformatf("rst_out0_%0d", e), dut_out(0, e), 0);
        rst = 1'b1;

        // Defaults with start held high through the whole run and the DONE cycle.
        alloc(0, 1'b0);
        xa[0] = 1; xa[1] = 2; xa[2] = 3; xa[3] = 4;
        wa[0] = 1; wa[1] = 1; wa[2] = 1; wa[3] = 1;
        wa[4] = 1; wa[5] = 2; wa[6] = 3; wa[7] = 4;
        ba[0] = 0; ba[1] = 10;
        run(0, 1'b1);
        check("done_cycle", mon_done_cyc, 193);
        for (int i = 0; i < 13; i++) check($sformatf("lit_e%0d", lit_e[i]), dut_out(0, lit_e[i]), lit_v[i]);

        // Sign and wrap on single-tap outputs.
        alloc(0, 1'b1);
        xa[0] = -3; xa[1] = 32'h10000;
        wa[0] = 5;  wa[4] = 32'h10000;
        ba[0] = 0;  ba[1] = 7;
        run(0, 1'b0);
        check("wrap_neg", dut_out(0, 0), 32'hFFFF_FFF1);
        check("wrap_mod", dut_out(0, 18), 32'd7);

        // Padding and overlapping taps: K=3, S=2, P=1.
        alloc(1, 1'b0);
        xa[0] = 1; xa[1] = 2; xa[2] = 3; xa[3] = 4;
        foreach (wa[i]) wa[i] = 1;
        run(1, 1'b0);
        check("pad_00", dut_out(1, 0), 1);
        check("pad_11", dut_out(1, 4), 10);
        check("pad_01", dut_out(1, 1), 3);

        for (int r = 0; r < 3; r++) begin
            alloc(0, 1'b1); run(0, 1'b0);
            alloc(1, 1'b1); run(1, 1'b0);
        end

        // Reset in cycle 50 of a run aborts it and clears the outputs.
        alloc(0, 1'b1);
        begin_run(0);
        start0 = 1'b0;
        repeat (49) begin @(posedge clk); #1; end
        mon_on = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_busy", {31'b0, busy0}, 0);
        check("abort_done", {31'b0, done0}, 0);
        for (int e = 0; e < ON0; e++) check($sformatf("abort_out%0d", e), dut_out(0, e), 0);
        alloc(0, 1'b1);
        run(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
